serial_transmitter: RTL and testbench

SERIAL_TRANSMITTER -- requirements
Module: serial_transmitter

---
 rtl/serial_transmitter_pkg.sv | 24 ++
 rtl/serial_transmitter_bit_counter.sv | 18 +
 rtl/serial_transmitter.sv | 78 +++++++
 tb/tb_serial_transmitter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/serial_transmitter_pkg.sv
// Shared definitions for the serial transmitter and its paired receiver bench.
package serial_transmitter_pkg;

  localparam int NBITS_DATA_DFLT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } tx_state_e;

  typedef struct packed {
    logic ready;
    logic shift_en;
    logic done;
    logic dout;
  } tx_out_t;

  // One spare bit so the counter can reach NBITS_DATA without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_transmitter_bit_counter.sv
// Bit counter for the transmitter: synchronous clear has priority over enable.
module bit_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + W'(1);
  end

endmodule

// File: rtl/serial_transmitter.sv
// LSB-first parallel-to-serial transmitter with ready/load handshake and done pulse.
module serial_transmitter
  import serial_transmitter_pkg::*;
#(
  parameter int NBITS_DATA = NBITS_DATA_DFLT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NBITS_DATA-1:0] Din,
  input  logic                  load,
  output logic                  ready,
  output logic                  Dout_serie,
  output logic                  shift_en,
  output logic                  done
);

  localparam int            CW   = cnt_width(NBITS_DATA);
  localparam logic [CW-1:0] LAST = CW'(NBITS_DATA - 1);

  tx_state_e             state, nxt;
  logic [NBITS_DATA-1:0] sh;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic                  in_shift;
  tx_out_t               o;

  assign in_shift = (state == SHIFT);
  assign accept   = load && o.ready;

  bit_counter #(.W(CW)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (in_shift),
    .count  (cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = SHIFT;
      SHIFT:   if (cnt == LAST) nxt = DONE;
      DONE:    nxt = accept ? SHIFT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs depend on registered state and sh only.
  always_comb begin
    o = '{ready: 1'b1, shift_en: 1'b0, done: 1'b0, dout: 1'b0};
    case (state)
      SHIFT: begin
        o.ready    = 1'b0;
        o.shift_en = 1'b1;
        o.dout     = sh[0];
      end
      DONE:    o.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         sh <= '0;
    else if (accept)   sh <= Din;
    else if (in_shift) sh <= {1'b0, sh[NBITS_DATA-1:1]};
  end

  assign ready      = o.ready;
  assign shift_en   = o.shift_en;
  assign done       = o.done;
  assign Dout_serie = o.dout;

endmodule

// File: tb/tb_serial_transmitter.sv
// Directed bench: 4-bit and 8-bit transmitters, each looped into a shift-right receiver model.
module tb_serial_transmitter;
  import serial_transmitter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] din;
  logic       load;
  logic       ready, dout, shift_en, done;
  logic [7:0] din8;
  logic       load8;
  logic       ready8, dout8, shift_en8, done8;
  logic [3:0] rx;
  logic [7:0] rx8;
  int         ncmp = 0;
  int         nerr = 0;
  int         cyc  = 0;
  int         t_d1, t_d2;

  serial_transmitter #(.NBITS_DATA(4)) dut4 (
    .clk(clk), .reset(reset), .Din(din), .load(load),
    .ready(ready), .Dout_serie(dout), .shift_en(shift_en), .done(done)
  );

  serial_transmitter #(.NBITS_DATA(8)) dut8 (
    .clk(clk), .reset(reset), .Din(din8), .load(load8),
    .ready(ready8), .Dout_serie(dout8), .shift_en(shift_en8), .done(done8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: serial data enters at MSB, shift right on each shift_en edge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      rx  <= '0;
      rx8 <= '0;
    end else begin
      if (shift_en)  rx  <= {dout, rx[3:1]};
      if (shift_en8) rx8 <= {dout8, rx8[7:1]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ready"}, ready, 1);
    chk({tag, " shift_en"}, shift_en, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " dout"}, dout, 0);
  endtask

  task automatic chk_bits(input string tag, input logic [3:0] w);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s bit%0d", tag, i), dout, w[i]);
      chk($sformatf("%s sen%0d", tag, i), shift_en, 1);
      chk($sformatf("%s rdy%0d", tag, i), ready, 0);
      tick();
    end
  endtask

  task automatic chk_done(input string tag, input logic [3:0] w);
    chk({tag, " done"}, done, 1);
    chk({tag, " done ready"}, ready, 1);
    chk({tag, " done sen"}, shift_en, 0);
    chk({tag, " done dout"}, dout, 0);
    chk({tag, " rx"}, rx, w);
  endtask

  task automatic send4(input string tag, input logic [3:0] w);
    din  = w;
    load = 1'b1;
    tick();
    load = 1'b0;
    chk_bits(tag, w);
    chk_done(tag, w);
    tick();
    chk_idle({tag, " after"});
  endtask

  initial begin
    reset = 1'b1; din = '0; load = 1'b0; din8 = '0; load8 = 1'b0;
    #12;
    chk_idle("reset");
    chk("reset ready8", ready8, 1);
    reset = 1'b0;
    tick();
    chk_idle("post reset");
    tick();
    chk_idle("post reset 2");

    // Basic word
    send4("w1011", 4'b1011);

    // Loopback words
    send4("lb0110", 4'b0110);
    send4("lb1000", 4'b1000);
    send4("lb0001", 4'b0001);

    // Back-to-back with load held high
    din = 4'hA; load = 1'b1;
    tick();
    din = 4'h5;
    chk_bits("b2b A", 4'hA);
    chk_done("b2b A", 4'hA);
    t_d1 = cyc;
    tick();
    load = 1'b0;
    chk_bits("b2b 5", 4'h5);
    chk_done("b2b 5", 4'h5);
    t_d2 = cyc;
    chk("b2b done gap", t_d2 - t_d1, 5);
    tick();
    chk_idle("b2b after");

    // Load and Din change during SHIFT are ignored
    din = 4'h3; load = 1'b1;
    tick();
    load = 1'b0;
    chk("ign bit0", dout, 1);
    tick();
    din = 4'hF; load = 1'b1;
    chk("ign bit1", dout, 1);
    tick();
    load = 1'b0;
    chk("ign bit2", dout, 0);
    chk("ign sen2", shift_en, 1);
    tick();
    chk("ign bit3", dout, 0);
    tick();
    chk_done("ign", 4'h3);
    tick();
    chk_idle("ign after");

    // Asynchronous reset mid-word
    din = 4'hC; load = 1'b1;
    tick();
    load = 1'b0;
    chk("rst bit0", dout, 0);
    tick();
    chk("rst bit1", dout, 0);
    tick();
    chk("rst bit2 before", dout, 1);
    #2 reset = 1'b1;
    #1;
    chk_idle("async rst");
    #2 reset = 1'b0;
    tick();
    chk_idle("rst release");
    tick();
    chk_idle("rst release 2");
    send4("after rst 9", 4'h9);

    // 8-bit instance
    din8 = 8'hA5; load8 = 1'b1;
    tick();
    load8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("w8 bit%0d", i), dout8, ((8'hA5 >> i) & 8'h01));
      chk($sformatf("w8 sen%0d", i), shift_en8, 1);
      chk($sformatf("w8 done%0d", i), done8, 0);
      tick();
    end
    chk("w8 done", done8, 1);
    chk("w8 done sen", shift_en8, 0);
    chk("w8 ready", ready8, 1);
    chk("w8 rx", rx8, 8'hA5);
    tick();
    chk("w8 after done", done8, 0);
    chk("w8 after ready", ready8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
